// File: rtl/gmm_pkg.sv
// gmm_pkg: shared FP constants and arbiter state encoding for the GMM pipeline
package gmm_pkg;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_Z = 2'd2, RETURN = 2'd3} state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit after i_last, wrapping modulo NUM_REQ
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  logic [IDX_W-1:0] w_j;
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    w_j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one strobe/ack FP divider among NUM_REQ requesters
module fp_div_arbiter
  import gmm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_z,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  output logic                   div_a_stb,
  output logic                   div_b_stb,
  input  logic                   div_a_ack,
  input  logic                   div_b_ack,
  input  logic [31:0]            div_z,
  input  logic                   div_z_stb,
  output logic                   div_z_ack,
  output logic                   busy,
  output logic [15:0]            ops_done
);
  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_grant, w_grant, r_last, w_last, w_win;
  logic [31:0]         r_div_a, w_div_a, r_div_b, w_div_b, r_rsp_z, w_rsp_z;
  logic                r_stb, w_stb, r_zack, w_zack, w_any;
  logic [NUM_REQ-1:0]  r_req_ack, w_req_ack, r_rsp_valid, w_rsp_valid;
  logic [15:0]         r_ops, w_ops;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  always_comb begin
    w_state     = r_state;
    w_grant     = r_grant;
    w_last      = r_last;
    w_div_a     = r_div_a;
    w_div_b     = r_div_b;
    w_rsp_z     = r_rsp_z;
    w_stb       = r_stb;
    w_zack      = 1'b0;
    w_req_ack   = '0;
    w_rsp_valid = r_rsp_valid;
    w_ops       = r_ops;
    case (r_state)
      IDLE: if (w_any) begin
        w_state   = ISSUE;
        w_grant   = w_win;
        w_div_a   = 32'(req_a >> {w_win, 5'd0});
        w_div_b   = 32'(req_b >> {w_win, 5'd0});
        w_req_ack = NUM_REQ'(1) << w_win;
        w_stb     = 1'b1;
      end
      ISSUE: if (div_a_ack && div_b_ack) begin
        w_stb   = 1'b0;
        w_state = WAIT_Z;
      end
      // ack is raised only after seeing the strobe, so the handshake is stb & registered ack
      WAIT_Z: if (div_z_stb && r_zack) begin
        w_rsp_z     = div_z;
        w_rsp_valid = NUM_REQ'(1) << r_grant;
        w_state     = RETURN;
      end else w_zack = div_z_stb;
      RETURN: if (rsp_ready[r_grant]) begin
        w_rsp_valid = '0;
        w_last      = r_grant;
        w_ops       = r_ops + 16'd1;
        w_state     = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_rsp_z     <= '0;
      r_stb       <= 1'b0;
      r_zack      <= 1'b0;
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      r_ops       <= '0;
    end else begin
      r_state     <= w_state;
      r_grant     <= w_grant;
      r_last      <= w_last;
      r_div_a     <= w_div_a;
      r_div_b     <= w_div_b;
      r_rsp_z     <= w_rsp_z;
      r_stb       <= w_stb;
      r_zack      <= w_zack;
      r_req_ack   <= w_req_ack;
      r_rsp_valid <= w_rsp_valid;
      r_ops       <= w_ops;
    end
  end

  assign req_ack   = r_req_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_z     = r_rsp_z;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign div_a_stb = r_stb;
  assign div_b_stb = r_stb;
  assign div_z_ack = r_zack;
  assign busy      = (r_state != IDLE);
  assign ops_done  = r_ops;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: random requesters and a behavioural divider against a round-robin reference model
module tb_fp_div_arbiter;
  import gmm_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, rsp_ready = '0;
  logic [N-1:0] req_ack, rsp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0] rsp_z, div_a, div_b, ops_w;
  logic [31:0] div_z = '0;
  logic div_a_stb, div_b_stb, div_z_ack, busy;
  logic div_a_ack = 1'b0, div_b_ack = 1'b0, div_z_stb = 1'b0;
  logic [15:0] ops_done;

  logic [31:0] a_of [N];
  logic [31:0] b_of [N];
  int want [N];
  int n_ack [N];
  bit fixed [N];
  int inflight = -1, last = N - 1;
  logic [15:0] exp_ops = '0;
  bit wd_en = 1'b0, rdy_all = 1'b1;
  logic [N-1:0] rdy_hold = '0, last_rv = '0;
  logic [31:0] last_z = '0;
  int order [$];
  int n_chk = 0, n_err = 0;

  logic p_rst = 1'b1, p_astb = 1'b0, p_aack = 1'b0, p_bstb = 1'b0, p_back = 1'b0, p_zstb = 1'b0, p_zack = 1'b0;
  logic [31:0] p_a = '0, p_b = '0, op_a = '0, op_b = '0;
  int ph = 0, cnt = 0, n_zack = 0, n_zhs = 0;

  always #5 clk = ~clk;

  assign req_a = {a_of[3], a_of[2], a_of[1], a_of[0]};
  assign req_b = {b_of[3], b_of[2], b_of[1], b_of[0]};
  assign ops_w = {16'h0, ops_done};

  fp_div_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .div_a(div_a), .div_b(div_b), .div_a_stb(div_a_stb), .div_b_stb(div_b_stb),
    .div_a_ack(div_a_ack), .div_b_ack(div_b_ack), .div_z(div_z), .div_z_stb(div_z_stb),
    .div_z_ack(div_z_ack), .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stand-in quotient: exact for the directed cases, an operand-dependent pattern otherwise
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return (a == 32'h0) ? FP_QNAN : FP_INF;
    if (b == FP_ONE) return a;
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) if (v[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction

  function automatic bit quiet();
    bit q = (inflight < 0) && (req_valid == '0);
    for (int i = 0; i < N; i++) if (want[i] > 0) q = 1'b0;
    return q;
  endfunction

  function automatic logic [31:0] seq();
    logic [31:0] s;
    s = '0;
    foreach (order[k]) s = (s << 4) | 32'(order[k]);
    return s;
  endfunction

  task automatic step();
    int w;
    @(negedge clk);
    chk("ops_done", ops_w, {16'h0, exp_ops});
    for (int i = 0; i < N; i++) if (req_ack[i]) n_ack[i]++;
    if (req_ack != '0) begin
      w = (inflight < 0) ? pick(req_valid, last) : -1;
      chk("grant", {28'h0, req_ack}, (w < 0) ? 32'h0 : 32'(1 << w));
      if (w >= 0) begin
        chk("div_a", div_a, a_of[w]);
        chk("div_b", div_b, b_of[w]);
        order.push_back(w);
        inflight = w;
        want[w]--;
        req_valid[w] = 1'b0;
        fixed[w] = 1'b0;
      end
    end
    if (rsp_valid != '0) begin
      last_rv = rsp_valid;
      last_z = rsp_z;
      chk("rsp_valid", {28'h0, rsp_valid}, (inflight < 0) ? 32'h0 : 32'(1 << inflight));
      if (inflight >= 0) chk("rsp_z", rsp_z, fdiv(a_of[inflight], b_of[inflight]));
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && wd_en && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      else if (!req_valid[i] && inflight != i && want[i] > 0) begin
        if (!fixed[i]) begin
          a_of[i] = $urandom;
          b_of[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        end
        req_valid[i] = 1'b1;
      end
    end
    rsp_ready = (rdy_all ? {N{1'b1}} : N'($urandom)) & ~rdy_hold;
    if (rsp_valid != '0 && inflight >= 0 && rsp_ready[inflight]) begin
      exp_ops++;
      last = inflight;
      inflight = -1;
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (!quiet() && c < budget) begin
      step();
      c++;
    end
    chk("drain", 32'(quiet()), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      fixed[i] = 1'b0;
    end
    inflight = -1;
    last = N - 1;
    exp_ops = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ack", {28'h0, req_ack}, 32'h0);
    chk("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_z", rsp_z, 32'h0);
    chk("rst_div_a", div_a, 32'h0);
    chk("rst_div_b", div_b, 32'h0);
    chk("rst_strobes", {29'h0, div_a_stb, div_b_stb, div_z_ack}, 32'h0);
    chk("rst_ops", ops_w, 32'h0);
    rst = 1'b0;
  endtask

  // Divider model: random operand acks, 1..4 cycle latency, holds z_stb until acknowledged
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (p_rst) begin
        div_a_ack = 1'b0;
        div_b_ack = 1'b0;
        div_z_stb = 1'b0;
        div_z = '0;
        ph = 0;
      end else begin
        if (p_zack) n_zack++;
        if (p_astb && p_aack && p_bstb && p_back) chk("stb_fall", {30'h0, div_a_stb, div_b_stb}, 32'h0);
        if (ph == 0) begin
          if (p_astb && p_aack && p_bstb && p_back) begin
            op_a = p_a;
            op_b = p_b;
            div_a_ack = 1'b0;
            div_b_ack = 1'b0;
            cnt = $urandom_range(1, 4);
            ph = 1;
          end else begin
            div_a_ack = 1'($urandom_range(0, 1));
            div_b_ack = 1'($urandom_range(0, 1));
          end
        end else if (ph == 1) begin
          cnt--;
          if (cnt == 0) begin
            div_z = fdiv(op_a, op_b);
            div_z_stb = 1'b1;
            ph = 2;
          end
        end else if (p_zstb && p_zack) begin
          div_z_stb = 1'b0;
          n_zhs++;
          ph = 0;
        end
      end
      p_rst = rst;
      p_astb = div_a_stb;
      p_bstb = div_b_stb;
      p_aack = div_a_ack;
      p_back = div_b_ack;
      p_zstb = div_z_stb;
      p_zack = div_z_ack;
      p_a = div_a;
      p_b = div_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] z0;
    bit seen;
    for (int i = 0; i < N; i++) begin
      a_of[i] = '0;
      b_of[i] = '0;
      n_ack[i] = 0;
      want[i] = 0;
      fixed[i] = 1'b0;
    end
    do_reset();

    a_of[0] = 32'h40C0_0000; b_of[0] = 32'h4000_0000; fixed[0] = 1'b1; want[0] = 1;
    drain(200);
    repeat (2) step();
    chk("single_ack_pulses", 32'(n_ack[0]), 32'h1);
    chk("single_rv", {28'h0, last_rv}, 32'h1);
    chk("single_z", last_z, 32'h4040_0000);
    chk("single_ops", ops_w, 32'h1);

    a_of[1] = FP_ONE; b_of[1] = 32'h0; fixed[1] = 1'b1; want[1] = 1;
    drain(200);
    repeat (2) step();
    chk("div0_rv", {28'h0, last_rv}, 32'h2);
    chk("div0_z", last_z, FP_INF);

    do_reset();
    order.delete();
    for (int i = 0; i < N; i++) want[i] = 1;
    drain(400);
    chk("order_all", seq(), 32'h0123);
    order.delete();
    want[0] = 1; want[2] = 1;
    drain(300);
    chk("order_0_2", seq(), 32'h02);

    rdy_hold = 4'b0001;
    want[0] = 1; want[1] = 1; want[2] = 1;
    c = 0;
    while (!rsp_valid[0] && c < 100) begin step(); c++; end
    chk("bp_reach", 32'(rsp_valid[0]), 32'h1);
    z0 = rsp_z;
    repeat (20) begin
      step();
      chk("bp_rv", {28'h0, rsp_valid}, 32'h1);
      chk("bp_z", rsp_z, z0);
      chk("bp_no_ack", {28'h0, req_ack}, 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    rdy_hold = '0;
    drain(400);

    want[2] = 1;
    c = 0;
    while (!(inflight == 2 && busy && !div_a_stb && rsp_valid == '0) && c < 100) begin step(); c++; end
    chk("wz_reach", 32'(inflight == 2 && busy && !div_a_stb), 32'h1);
    do_reset();
    seen = 1'b0;
    repeat (10) begin
      step();
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'h0);
    order.delete();
    a_of[0] = 32'h40C0_0000; b_of[0] = 32'h4000_0000; fixed[0] = 1'b1;
    want[0] = 1; want[1] = 1;
    drain(300);
    repeat (2) step();
    chk("post_rst_order", seq(), 32'h01);
    chk("post_rst_ops", ops_w, 32'h2);

    do_reset();
    wd_en = 1'b1;
    rdy_all = 1'b0;
    for (int i = 0; i < N; i++) want[i] = $urandom_range(4, 8);
    drain(4000);
    wd_en = 1'b0;
    rdy_all = 1'b1;
    repeat (3) step();
    chk("zack_one_per_op", 32'(n_zack), 32'(n_zhs));
    chk("zack_activity", 32'(n_zhs > 20), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
